// File: rtl/ps_conv_ctrl.sv
// Sequencer and two-way arbiter feeding a 32-to-8 parallel/serial converter.
// Optional macro PS_CONV_CTRL_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module ps_conv_ctrl #(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [31:0] req0_word,
  output logic        req0_gnt,
  input  logic        req1_vld,
  input  logic [31:0] req1_word,
  output logic        req1_gnt,
  input  logic        hold,
  output logic        pld,
  output logic [31:0] pdin,
  output logic [7:0]  din,
  output logic        byte_vld,
  output logic [1:0]  byte_idx,
  output logic        byte_last,
  output logic        byte_src
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  localparam logic [1:0] GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] gapcnt_q, gapcnt_d;
  logic       owner_q, owner_d;
  logic       both_vld;
  logic       winner;
  logic       can_load;

`ifdef PS_CONV_CTRL_RR_EN
  logic rr_ptr_q, rr_ptr_d;
`endif

  assign din      = 8'h00;
  assign both_vld = req0_vld & req1_vld;

`ifdef PS_CONV_CTRL_RR_EN
  assign winner = both_vld ? rr_ptr_q : req1_vld;
`else
  assign winner = both_vld ? 1'b0 : req1_vld;
`endif

  // A word's byte 0 leaves in the load cycle, so back-to-back words load from IDLE
  // in the cycle right after byte 3; this keeps byte_vld continuous at GAP=0.
  assign can_load = !rst && !hold && (req0_vld || req1_vld) && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gapcnt_d  = gapcnt_q;
    owner_d   = owner_q;
`ifdef PS_CONV_CTRL_RR_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    pld       = 1'b0;
    pdin      = 32'h0;
    req0_gnt  = 1'b0;
    req1_gnt  = 1'b0;
    byte_vld  = 1'b0;
    byte_idx  = 2'd0;
    byte_last = 1'b0;
    byte_src  = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (can_load) begin
            pld      = 1'b1;
            pdin     = winner ? req1_word : req0_word;
            req0_gnt = !winner;
            req1_gnt = winner;
            byte_vld = 1'b1;
            byte_src = winner;
            state_d  = SHIFT;
            cnt_d    = 2'd1;
            owner_d  = winner;
`ifdef PS_CONV_CTRL_RR_EN
            rr_ptr_d = !winner;
`endif
          end
        end
        SHIFT: begin
          byte_vld  = 1'b1;
          byte_idx  = cnt_q;
          byte_src  = owner_q;
          byte_last = (cnt_q == 2'd3);
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d  = (GAP > 0) ? GAPW : IDLE;
            gapcnt_d = 2'd0;
          end
        end
        GAPW: begin
          if (gapcnt_q == GAP_LAST) state_d = IDLE;
          else                      gapcnt_d = gapcnt_q + 2'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      gapcnt_q <= 2'd0;
      owner_q  <= 1'b0;
`ifdef PS_CONV_CTRL_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gapcnt_q <= gapcnt_d;
      owner_q  <= owner_d;
`ifdef PS_CONV_CTRL_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule
